// File: rtl/mem_read_sweeper.sv
// Sweeps a single-port memory from address 0 to NDEPTH-1 and streams each word with its address.
// Optional build macro MEM_RD_CHECKSUM_EN enables the XOR checksum of all accepted words.
module mem_read_sweeper #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             mem_we,
  output logic             mem_re,
  output logic [DEPTH-1:0] mem_addr,
  input  logic [WIDTH-1:0] mem_rdData,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [DEPTH-1:0] out_addr,
  output logic [WIDTH-1:0] checksum
);

  localparam int unsigned NDEPTH = 1 << DEPTH;
  localparam int unsigned PW     = DEPTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic               inflight_q, inflight_d;
  logic [DEPTH-1:0]   infl_addr_q, infl_addr_d;
  logic               head_v_q, head_v_d, tail_v_q, tail_v_d;
  logic [WIDTH-1:0]   head_data_q, head_data_d, tail_data_q, tail_data_d;
  logic [DEPTH-1:0]   head_addr_q, head_addr_d, tail_addr_q, tail_addr_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               pop_c, issue_c;
  logic [1:0]         occ_c;

  // Occupancy counts in-flight reads so a stalled consumer can never overflow the FIFO.
  assign pop_c   = head_v_q & out_ready;
  assign occ_c   = 2'(head_v_q) + 2'(tail_v_q) + 2'(inflight_q) - 2'(pop_c);
  assign issue_c = (state_q == S_READ) && (occ_c < 2'd2);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    inflight_d  = issue_c;
    infl_addr_d = issue_c ? ptr_q[DEPTH-1:0] : infl_addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          ptr_d   = '0;
        end
      end
      S_READ: begin
        if (issue_c) begin
          ptr_d = ptr_q + PW'(1);
          if (ptr_q == PW'(NDEPTH - 1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!inflight_q && !tail_v_q && (!head_v_q || pop_c)) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // Two-entry output FIFO: head drives the stream, tail absorbs one word during a stall.
  always_comb begin
    head_v_d    = head_v_q;
    head_data_d = head_data_q;
    head_addr_d = head_addr_q;
    tail_v_d    = tail_v_q;
    tail_data_d = tail_data_q;
    tail_addr_d = tail_addr_q;
    if (pop_c) begin
      if (tail_v_q) begin
        head_data_d = tail_data_q;
        head_addr_d = tail_addr_q;
        tail_v_d    = inflight_q;
        if (inflight_q) begin
          tail_data_d = mem_rdData;
          tail_addr_d = infl_addr_q;
        end
      end else if (inflight_q) begin
        head_data_d = mem_rdData;
        head_addr_d = infl_addr_q;
      end else begin
        head_v_d = 1'b0;
      end
    end else if (inflight_q) begin
      if (!head_v_q) begin
        head_v_d    = 1'b1;
        head_data_d = mem_rdData;
        head_addr_d = infl_addr_q;
      end else begin
        tail_v_d    = 1'b1;
        tail_data_d = mem_rdData;
        tail_addr_d = infl_addr_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      inflight_q  <= 1'b0;
      infl_addr_q <= '0;
      head_v_q    <= 1'b0;
      head_data_q <= '0;
      head_addr_q <= '0;
      tail_v_q    <= 1'b0;
      tail_data_q <= '0;
      tail_addr_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      inflight_q  <= inflight_d;
      infl_addr_q <= infl_addr_d;
      head_v_q    <= head_v_d;
      head_data_q <= head_data_d;
      head_addr_q <= head_addr_d;
      tail_v_q    <= tail_v_d;
      tail_data_q <= tail_data_d;
      tail_addr_q <= tail_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef MEM_RD_CHECKSUM_EN
  logic [WIDTH-1:0] ck_q, ck_d;

  always_comb begin
    ck_d = ck_q;
    if ((state_q == S_IDLE) && start) ck_d = '0;
    else if (pop_c)                   ck_d = ck_q ^ head_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ck_q <= '0;
    else     ck_q <= ck_d;
  end

  assign checksum = ck_q;
`else
  assign checksum = '0;
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_we    = 1'b0;
  assign mem_re    = issue_c;
  assign mem_addr  = ptr_q[DEPTH-1:0];
  assign out_valid = head_v_q;
  assign out_data  = head_data_q;
  assign out_addr  = head_addr_q;

endmodule
